if_fetch: RTL and testbench

Instruction-fetch stage of the pipelined processor, and the producer side of the IF/ID pipeline register. It owns the program counter and fetches instructions from instruction memory over a req/ack handshake. It presents each instruction with its next-PC (`PC+4`) to the IF/ID register, holds it until that register accepts it, and redirects fetch on taken branches/jumps resolved downstream.

---
 rtl/if_fetch_pkg.sv | 17 +
 rtl/if_fetch.sv | 134 +++++++++++++
 tb/tb_if_fetch.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared fetch-stage types and constants
package if_fetch_pkg;

    // Fetch-stage control states
    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    // Instruction presented to IF/ID when nothing valid is held
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Sequential PC increment (byte addressed, 32-bit instructions)
    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage, producer side of IF/ID
module if_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = if_fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_IFWrite,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] NPC_if_o,
    output logic [31:0] Instr_if_o,
    output logic        IF_valid_o
);

    import if_fetch_pkg::*;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        kill_q, kill_d;
    // One-cycle request bubble after an ack whose data was thrown away,
    // so the memory sees a fresh request for the redirected address.
    logic        gap_q, gap_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] npc_q, npc_d;
    logic        valid_q, valid_d;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            redir_pc_q <= RESET_PC;
            kill_q     <= 1'b0;
            gap_q      <= 1'b0;
            instr_q    <= NOP_INSTR;
            npc_q      <= 32'h0000_0000;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redir_pc_q <= redir_pc_d;
            kill_q     <= kill_d;
            gap_q      <= gap_d;
            instr_q    <= instr_d;
            npc_q      <= npc_d;
            valid_q    <= valid_d;
        end
    end

    // Next-state logic; a redirect always wins over capture or consume
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redir_pc_d = redir_pc_q;
        kill_d     = kill_q;
        gap_d      = 1'b0;
        instr_d    = instr_q;
        npc_d      = npc_q;
        valid_d    = valid_q;

        case (state_q)
            S_BOOT: begin
                // Any ack seen here belongs to an aborted request: ignore it
                if (branch_taken) begin
                    pc_d = branch_target;
                end
                state_d = S_FETCH;
            end

            S_FETCH: begin
                if (gap_q) begin
                    // No request outstanding yet, so a redirect retargets directly
                    if (branch_taken) begin
                        pc_d = branch_target;
                    end
                end else if (imem_ack) begin
                    if (branch_taken) begin
                        pc_d   = branch_target;
                        kill_d = 1'b0;
                        gap_d  = 1'b1;
                    end else if (kill_q) begin
                        pc_d   = redir_pc_q;
                        kill_d = 1'b0;
                        gap_d  = 1'b1;
                    end else begin
                        instr_d = imem_rdata;
                        npc_d   = pc_q + PC_STEP;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end
                end else if (branch_taken) begin
                    // Address must stay stable until ack; remember the target
                    redir_pc_d = branch_target;
                    kill_d     = 1'b1;
                end
            end

            S_HOLD: begin
                if (branch_taken) begin
                    pc_d    = branch_target;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = S_FETCH;
                end else if (PC_IFWrite) begin
                    pc_d    = pc_q + PC_STEP;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // Request decoded from registered state only; no path from imem_ack
    always_comb begin
        imem_req  = (state_q == S_FETCH) && !gap_q;
        imem_addr = pc_q;
    end

    assign NPC_if_o   = npc_q;
    assign Instr_if_o = instr_q;
    assign IF_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for if_fetch
module tb_if_fetch;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        PC_IFWrite;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] NPC_if_o;
    logic [31:0] Instr_if_o;
    logic        IF_valid_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        int          lat;
        logic [31:0] rdata;
        int          stall;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] npc;
    } exp_t;

    vec_t vecs[4];
    exp_t sb[$];

    if_fetch #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .PC_IFWrite   (PC_IFWrite),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .NPC_if_o     (NPC_if_o),
        .Instr_if_o   (Instr_if_o),
        .IF_valid_o   (IF_valid_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        chk("req_wait", {31'd0, imem_req}, 32'd1);
    endtask

    // One fetch: optional wait states, capture, optional stall, consume
    task automatic fetch_one(input logic [31:0] addr, input int lat,
                             input logic [31:0] rdata, input int stall);
        exp_t e;
        logic [31:0] fi, fn;
        wait_req();
        chk("fetch_addr", imem_addr, addr);
        for (int i = 0; i < lat; i++) begin
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, addr);
            chk("wait_valid", {31'd0, IF_valid_o}, 32'd0);
            tick();
        end
        chk("ack_req", {31'd0, imem_req}, 32'd1);
        chk("ack_addr", imem_addr, addr);
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        PC_IFWrite = 1'b0;
        sb.push_back('{instr: rdata, npc: addr + 32'd4});
        tick();
        imem_ack = 1'b0;
        e = sb.pop_front();
        chk("cap_valid", {31'd0, IF_valid_o}, 32'd1);
        chk("cap_instr", Instr_if_o, e.instr);
        chk("cap_npc", NPC_if_o, e.npc);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        fi = e.instr;
        fn = e.npc;
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("stall_valid", {31'd0, IF_valid_o}, 32'd1);
            chk("stall_instr", Instr_if_o, fi);
            chk("stall_npc", NPC_if_o, fn);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        PC_IFWrite = 1'b1;
        tick();
        PC_IFWrite = 1'b0;
        chk("cons_valid", {31'd0, IF_valid_o}, 32'd0);
        chk("cons_instr", Instr_if_o, NOP);
        chk("next_req", {31'd0, imem_req}, 32'd1);
        chk("next_addr", imem_addr, addr + 32'd4);
    endtask

    initial begin
        exp_t e;
        vecs[0] = '{addr: 32'h0040_0000, lat: 0, rdata: 32'h2008_0005, stall: 0};
        vecs[1] = '{addr: 32'h0040_0004, lat: 0, rdata: 32'h1111_0001, stall: 5};
        vecs[2] = '{addr: 32'h0040_0008, lat: 3, rdata: 32'h2222_0002, stall: 0};
        vecs[3] = '{addr: 32'h0040_000C, lat: 1, rdata: 32'h3333_0003, stall: 2};

        rst           = 1'b1;
        PC_IFWrite    = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
        repeat (3) tick();

        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_valid", {31'd0, IF_valid_o}, 32'd0);
        chk("rst_instr", Instr_if_o, NOP);
        chk("rst_npc", NPC_if_o, 32'h0);

        rst = 1'b0;
        tick();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, RST_PC);

        for (int v = 0; v < 4; v++) begin
            fetch_one(vecs[v].addr, vecs[v].lat, vecs[v].rdata, vecs[v].stall);
        end

        // Two redirects during an outstanding fetch: latest target wins
        branch_taken  = 1'b1;
        branch_target = 32'h0040_0100;
        tick();
        branch_taken = 1'b0;
        chk("kill_addr_stable", imem_addr, 32'h0040_0010);
        chk("kill_req_stable", {31'd0, imem_req}, 32'd1);
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h0040_0200;
        tick();
        branch_taken = 1'b0;
        imem_ack     = 1'b1;
        imem_rdata   = 32'hDEAD_0001;
        tick();
        imem_ack = 1'b0;
        chk("kill_drop_valid", {31'd0, IF_valid_o}, 32'd0);
        chk("kill_gap_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("kill_redir_req", {31'd0, imem_req}, 32'd1);
        chk("kill_redir_addr", imem_addr, 32'h0040_0200);
        fetch_one(32'h0040_0200, 0, 32'h4444_0004, 0);

        // Branch and ack in the same cycle
        branch_taken  = 1'b1;
        branch_target = 32'h0040_0100;
        imem_ack      = 1'b1;
        imem_rdata    = 32'hDEAD_0002;
        tick();
        branch_taken = 1'b0;
        imem_ack     = 1'b0;
        chk("same_drop_valid", {31'd0, IF_valid_o}, 32'd0);
        tick();
        chk("same_redir_req", {31'd0, imem_req}, 32'd1);
        chk("same_redir_addr", imem_addr, 32'h0040_0100);

        // Redirect in hold together with consume
        imem_ack   = 1'b1;
        imem_rdata = 32'h5555_0005;
        sb.push_back('{instr: 32'h5555_0005, npc: 32'h0040_0104});
        tick();
        imem_ack = 1'b0;
        e = sb.pop_front();
        chk("hold_br_instr", Instr_if_o, e.instr);
        chk("hold_br_npc", NPC_if_o, e.npc);
        PC_IFWrite    = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h0040_0300;
        tick();
        PC_IFWrite   = 1'b0;
        branch_taken = 1'b0;
        chk("hold_br_valid", {31'd0, IF_valid_o}, 32'd0);
        chk("hold_br_req", {31'd0, imem_req}, 32'd1);
        chk("hold_br_addr", imem_addr, 32'h0040_0300);

        // Move to the top of the address space and wrap
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        imem_ack      = 1'b1;
        imem_rdata    = 32'hDEAD_0003;
        tick();
        branch_taken = 1'b0;
        imem_ack     = 1'b0;
        tick();
        fetch_one(32'hFFFF_FFFC, 0, 32'h6666_0006, 0);

        // Reset in the middle of a fetch, late ack lands in boot
        tick();
        chk("mid_req", {31'd0, imem_req}, 32'd1);
        chk("mid_addr", imem_addr, 32'h0000_0000);
        rst = 1'b1;
        tick();
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_addr", imem_addr, RST_PC);
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_0004;
        tick();
        imem_ack = 1'b0;
        chk("late_ack_valid", {31'd0, IF_valid_o}, 32'd0);
        chk("late_ack_instr", Instr_if_o, NOP);
        chk("late_ack_req", {31'd0, imem_req}, 32'd1);
        chk("late_ack_addr", imem_addr, RST_PC);
        fetch_one(RST_PC, 1, 32'h7777_0007, 0);

        chk("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
